// File: rtl/traffic_light_pkg.sv
// Shared phase codes, lamp patterns and timer width
// for the two-road traffic-light controller.
package traffic_light_pkg;

  localparam int TW = 6;

  typedef enum logic [1:0] {
    S_AG = 2'd0,
    S_AY = 2'd1,
    S_BG = 2'd2,
    S_BY = 2'd3
  } phase_t;

  // {A_red, A_yellow, A_green, B_red, B_yellow, B_green}
  localparam logic [5:0] LED_AG = 6'b001_100;
  localparam logic [5:0] LED_AY = 6'b010_100;
  localparam logic [5:0] LED_BG = 6'b100_001;
  localparam logic [5:0] LED_BY = 6'b100_010;

  function automatic logic [5:0] led_of(
    input phase_t p
  );
    led_of = LED_AG;
    unique case (p)
      S_AG: led_of = LED_AG;
      S_AY: led_of = LED_AY;
      S_BG: led_of = LED_BG;
      S_BY: led_of = LED_BY;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_tick_gen.sv
// Tick prescaler: one-clock pulse every CLK_DIV clocks.
// Only instantiated when TL_PRESCALER_EN is defined.
module tick_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic CLK,
  input  logic RSTn,
  output logic tick
);

  localparam int CW =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road traffic-light FSM with per-road countdowns.
// Define TL_PRESCALER_EN to divide ticks by CLK_DIV.
module traffic_light_ctrl
  import traffic_light_pkg::*;
#(
  parameter int GREEN_A = 30,
  parameter int GREEN_B = 20,
  parameter int YELLOW  = 5,
  parameter int CLK_DIV = 1
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          AS,
  input  logic          BS,
  output logic [1:0]    state,
  output logic [TW-1:0] A_time,
  output logic [TW-1:0] B_time,
  output logic [5:0]    led
);

  localparam logic [TW-1:0] T_GA  =
    TW'(GREEN_A);
  localparam logic [TW-1:0] T_GAY =
    TW'(GREEN_A + YELLOW);
  localparam logic [TW-1:0] T_GB  =
    TW'(GREEN_B);
  localparam logic [TW-1:0] T_GBY =
    TW'(GREEN_B + YELLOW);
  localparam logic [TW-1:0] T_Y   =
    TW'(YELLOW);
  localparam logic [TW-1:0] T_ONE =
    TW'(1);

  logic tick;

`ifdef TL_PRESCALER_EN
  tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .CLK (CLK),
    .RSTn(RSTn),
    .tick(tick)
  );
`else
  localparam int unused_clk_div = CLK_DIV;
  assign tick = 1'b1;
`endif

  phase_t        st_q, st_d;
  logic [TW-1:0] a_q, a_d;
  logic [TW-1:0] b_q, b_d;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      st_q <= S_AG;
      a_q  <= T_GA;
      b_q  <= T_GAY;
    end else begin
      st_q <= st_d;
      a_q  <= a_d;
      b_q  <= b_d;
    end
  end

  // Greens extend when the other road has no demand;
  // yellows always run to completion.
  always_comb begin
    st_d = st_q;
    a_d  = a_q;
    b_d  = b_q;
    if (tick) begin
      unique case (st_q)
        S_AG: begin
          if (a_q != T_ONE) begin
            a_d = a_q - 1'b1;
            b_d = b_q - 1'b1;
          end else if (BS) begin
            st_d = S_AY;
            a_d  = T_Y;
            b_d  = T_Y;
          end else begin
            a_d = T_GA;
            b_d = T_GAY;
          end
        end
        S_AY: begin
          if (a_q != T_ONE) begin
            a_d = a_q - 1'b1;
            b_d = b_q - 1'b1;
          end else begin
            st_d = S_BG;
            a_d  = T_GBY;
            b_d  = T_GB;
          end
        end
        S_BG: begin
          if (b_q != T_ONE) begin
            a_d = a_q - 1'b1;
            b_d = b_q - 1'b1;
          end else if (AS) begin
            st_d = S_BY;
            a_d  = T_Y;
            b_d  = T_Y;
          end else begin
            a_d = T_GBY;
            b_d = T_GB;
          end
        end
        S_BY: begin
          if (b_q != T_ONE) begin
            a_d = a_q - 1'b1;
            b_d = b_q - 1'b1;
          end else begin
            st_d = S_AG;
            a_d  = T_GA;
            b_d  = T_GAY;
          end
        end
      endcase
    end
  end

  assign state  = st_q;
  assign A_time = a_q;
  assign B_time = b_q;
  assign led    = led_of(st_q);

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench for traffic_light_ctrl (default build,
// one tick per clock, default durations 30/20/5).
module tb_traffic_light_ctrl;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       AS;
  logic       BS;
  logic [1:0] state;
  logic [5:0] A_time;
  logic [5:0] B_time;
  logic [5:0] led;

  traffic_light_ctrl dut (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .AS    (AS),
    .BS    (BS),
    .state (state),
    .A_time(A_time),
    .B_time(B_time),
    .led   (led)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] st;
    logic [5:0] a;
    logic [5:0] b;
    logic [5:0] led;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  event chk_ev;

  function automatic logic [5:0] led_exp(
    input logic [1:0] st
  );
    case (st)
      2'd0:    led_exp = 6'b001100;
      2'd1:    led_exp = 6'b010100;
      2'd2:    led_exp = 6'b100001;
      default: led_exp = 6'b100010;
    endcase
  endfunction

  task automatic push(
    input logic [1:0] st,
    input int a,
    input int b
  );
    exp_t e;
    e.st  = st;
    e.a   = 6'(a);
    e.b   = 6'(b);
    e.led = led_exp(st);
    q.push_back(e);
  endtask

  task automatic check_one(input string tag);
    exp_t e;
    if (q.size() == 0) return;
    e = q.pop_front();
    n_chk++;
    if (state !== e.st || A_time !== e.a ||
        B_time !== e.b || led !== e.led) begin
      n_fail++;
      $display(
        "FAIL %s @%0t: got st=%0d A=%0d B=%0d led=%b, want st=%0d A=%0d B=%0d led=%b",
        tag, $time, state, A_time, B_time, led,
        e.st, e.a, e.b, e.led);
    end
  endtask

  always @(negedge CLK)
    if (mon_en) check_one("tick");

  always @(chk_ev)
    check_one("async_rst");

  // Expect n ticks in phase st counting down from a0/b0.
  // Sensors take as1/bs1 after the first tick and
  // as2/bs2 after tick k; the last value set governs
  // the exit decision of this segment.
  task automatic run(
    input logic [1:0] st,
    input int a0,
    input int b0,
    input int n,
    input logic as1,
    input logic bs1,
    input logic as2,
    input logic bs2,
    input int k
  );
    for (int i = 0; i < n; i++)
      push(st, a0 - i, b0 - i);
    for (int i = 1; i <= n; i++) begin
      @(negedge CLK);
      if (i == 1) begin AS = as1; BS = bs1; end
      if (i == k) begin AS = as2; BS = bs2; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RSTn = 1'b0;
    AS   = 1'b1;
    BS   = 1'b1;
    push(2'd0, 30, 35);
    mon_en = 1'b1;
    @(negedge CLK);
    #2 RSTn = 1'b1;

    run(2'd0, 29, 34, 29, 1, 1, 1, 1, 1);
    // sensors low during yellow must not matter
    run(2'd1, 5, 5, 5, 0, 0, 0, 0, 1);
    run(2'd2, 25, 20, 20, 1, 1, 1, 1, 1);
    run(2'd3, 5, 5, 5, 0, 0, 0, 0, 1);
    // no B demand: A green extends
    run(2'd0, 30, 35, 30, 1, 0, 1, 0, 1);
    // B demand raised mid-green
    run(2'd0, 30, 35, 30, 1, 0, 1, 1, 15);
    run(2'd1, 5, 5, 5, 1, 1, 1, 1, 1);
    // no A demand: B green extends
    run(2'd2, 25, 20, 20, 0, 1, 0, 1, 1);
    // A demand pulses then drops before expiry
    run(2'd2, 25, 20, 20, 1, 1, 0, 1, 10);
    run(2'd2, 25, 20, 20, 0, 1, 1, 1, 10);
    run(2'd3, 5, 5, 5, 1, 1, 1, 1, 1);
    // AS low during S0 is irrelevant
    run(2'd0, 30, 35, 30, 0, 1, 0, 1, 1);
    run(2'd1, 5, 5, 5, 1, 1, 1, 1, 1);

    // async reset mid-S2, between edges
    for (int i = 0; i < 7; i++)
      push(2'd2, 25 - i, 20 - i);
    repeat (7) @(negedge CLK);
    @(posedge CLK);
    #2 RSTn = 1'b0;
    #1 push(2'd0, 30, 35);
    -> chk_ev;
    push(2'd0, 30, 35);
    @(negedge CLK);
    #2 RSTn = 1'b1;

    run(2'd0, 29, 34, 29, 1, 1, 1, 1, 1);
    run(2'd1, 5, 5, 5, 1, 1, 1, 1, 1);

    @(posedge CLK);
    mon_en = 1'b0;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0",
               q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
